// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding, default frame shape and oversampling constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int DBIT_DEF    = 8;
   localparam int SB_TICK_DEF = 16;
   localparam int OS_RATE     = 16;
   localparam int MID_TICK    = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so idle-high lines stay idle in reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic q_out
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   // Next values: each stage copies the one before it.
   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   // Synchronizer chain registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q;

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1-style UART receiver on a 16x oversample tick.
// Centre sampling, start glitch rejection, valid/ready output.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick16,
   input  logic            rx_in,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            frame_err,
   output logic            overrun
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [3:0]    CNT_MID  = 4'(MID_TICK);
   localparam logic [3:0]    CNT_BIT  = 4'(OS_RATE - 1);
   localparam logic [3:0]    CNT_STOP = 4'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

   logic rx_s;

   rx_state_e state_d, state_q;
   logic [3:0]      cnt_d, cnt_q;
   logic [NW-1:0]   n_d, n_q;
   logic [DBIT-1:0] shreg_d, shreg_q;
   logic [DBIT-1:0] data_d, data_q;
   logic            valid_d, valid_q;
   logic            ferr_d, ferr_q;
   logic            ovr_d, ovr_q;
   logic            done;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_in  (rx_in),
      .q_out (rx_s)
   );

   // Frame FSM: advances only on tick16, flags a good or bad stop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      done    = 1'b0;
      ferr_d  = 1'b0;
      if (tick16) begin
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_d = '0;
                  if (!rx_s) begin
                     state_d = DATA;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (cnt_q == CNT_BIT) begin
                  shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                  cnt_d   = '0;
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            STOP: begin
               if (cnt_q == CNT_STOP) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  if (rx_s) begin
                     done = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output register: accept clears, completion loads or overruns.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end
      if (done) begin
         if (!valid_q || rx_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16.
// tick16 every 4 clk, one bit = 16 ticks = 64 clk.
module tb_uart_rx_os16;

   localparam int BITCLK = 64;

   logic       clk;
   logic       reset;
   logic       tick16;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   int checks;
   int errors;

   int fe_cyc;
   int ov_cyc;
   int vld_cyc;
   logic [7:0] acc_q[$];
   logic [1:0] tdiv;

   uart_rx_os16 dut (
      .clk       (clk),
      .reset     (reset),
      .tick16    (tick16),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tick16 generator: one cycle in four
   initial begin
      tdiv   = 2'd0;
      tick16 = 1'b0;
   end
   always @(negedge clk) begin
      tdiv   = tdiv + 2'd1;
      tick16 = (tdiv == 2'd0);
   end

   // Monitor: pulse widths and accepted bytes
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cyc++;
      if (overrun === 1'b1) ov_cyc++;
      if (rx_valid === 1'b1) vld_cyc++;
      if (rx_valid === 1'b1 && rx_ready === 1'b1)
         acc_q.push_back(rx_data);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      fe_cyc  = 0;
      ov_cyc  = 0;
      vld_cyc = 0;
      acc_q.delete();
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      wait_clks(BITCLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stp);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stp);
      rx_in = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      rx_in    = 1'b1;
      rx_ready = 1'b0;
      clear_mon();
      wait_clks(5);
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b want 0", rx_valid);
      end
      checks++;
      if (rx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h want 00", rx_data);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ferr got %b want 0", frame_err);
      end
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovr got %b want 0", overrun);
      end
      reset = 1'b0;
      wait_clks(20);
   endtask

   task automatic test_basic();
      clear_mon();
      rx_ready = 1'b0;
      send_frame(8'hA5, 1'b1);
      wait_clks(20);
      checks++;
      if (rx_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_valid got %b want 1", rx_valid);
      end
      checks++;
      if (rx_data !== 8'hA5) begin
         errors++;
         $display("FAIL basic_data got %h want a5", rx_data);
      end
      wait_clks(50);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
         errors++;
         $display("FAIL basic_hold got %b/%h want 1/a5",
                  rx_valid, rx_data);
      end
      checks++;
      if (fe_cyc !== 0 || ov_cyc !== 0) begin
         errors++;
         $display("FAIL basic_flags got %0d/%0d want 0/0",
                  fe_cyc, ov_cyc);
      end
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept got %b want 0", rx_valid);
      end
      checks++;
      if (acc_q.size() !== 1) begin
         errors++;
         $display("FAIL basic_nacc got %0d want 1", acc_q.size());
      end else if (acc_q[0] !== 8'hA5) begin
         errors++;
         $display("FAIL basic_acc got %h want a5", acc_q[0]);
      end
      wait_clks(10);
   endtask

   task automatic test_glitch();
      clear_mon();
      rx_ready = 1'b0;
      rx_in    = 1'b0;
      wait_clks(12);
      rx_in = 1'b1;
      wait_clks(120);
      checks++;
      if (rx_valid !== 1'b0 || vld_cyc !== 0) begin
         errors++;
         $display("FAIL glitch_valid got %b/%0d want 0/0",
                  rx_valid, vld_cyc);
      end
      checks++;
      if (fe_cyc !== 0) begin
         errors++;
         $display("FAIL glitch_ferr got %0d want 0", fe_cyc);
      end
      checks++;
      if (ov_cyc !== 0) begin
         errors++;
         $display("FAIL glitch_ovr got %0d want 0", ov_cyc);
      end
   endtask

   task automatic test_frame_err();
      clear_mon();
      rx_ready = 1'b0;
      send_frame(8'h3C, 1'b0);
      wait_clks(128);
      checks++;
      if (fe_cyc !== 1) begin
         errors++;
         $display("FAIL ferr_pulse got %0d want 1", fe_cyc);
      end
      checks++;
      if (rx_valid !== 1'b0 || vld_cyc !== 0) begin
         errors++;
         $display("FAIL ferr_valid got %b/%0d want 0/0",
                  rx_valid, vld_cyc);
      end
      checks++;
      if (ov_cyc !== 0) begin
         errors++;
         $display("FAIL ferr_ovr got %0d want 0", ov_cyc);
      end
   endtask

   task automatic test_overrun();
      clear_mon();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_clks(40);
      checks++;
      if (rx_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_valid got %b want 1", rx_valid);
      end
      checks++;
      if (rx_data !== 8'h11) begin
         errors++;
         $display("FAIL ovr_data got %h want 11", rx_data);
      end
      checks++;
      if (ov_cyc !== 1) begin
         errors++;
         $display("FAIL ovr_pulse got %0d want 1", ov_cyc);
      end
      checks++;
      if (fe_cyc !== 0) begin
         errors++;
         $display("FAIL ovr_ferr got %0d want 0", fe_cyc);
      end
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovr_accept got %b want 0", rx_valid);
      end
      checks++;
      if (acc_q.size() !== 1) begin
         errors++;
         $display("FAIL ovr_nacc got %0d want 1", acc_q.size());
      end else if (acc_q[0] !== 8'h11) begin
         errors++;
         $display("FAIL ovr_acc got %h want 11", acc_q[0]);
      end
      wait_clks(10);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      exp[0] = 8'h55;
      exp[1] = 8'hAA;
      exp[2] = 8'hFF;
      clear_mon();
      rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
      wait_clks(40);
      checks++;
      if (vld_cyc !== 3) begin
         errors++;
         $display("FAIL b2b_vcyc got %0d want 3", vld_cyc);
      end
      checks++;
      if (acc_q.size() !== 3) begin
         errors++;
         $display("FAIL b2b_nacc got %0d want 3", acc_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < acc_q.size()) begin
            checks++;
            if (acc_q[i] !== exp[i]) begin
               errors++;
               $display("FAIL b2b_byte%0d got %h want %h",
                        i, acc_q[i], exp[i]);
            end
         end
      end
      checks++;
      if (ov_cyc !== 0 || fe_cyc !== 0) begin
         errors++;
         $display("FAIL b2b_flags got %0d/%0d want 0/0",
                  ov_cyc, fe_cyc);
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'h0F;
      clear_mon();
      rx_ready = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx_in = d[4];
      wait_clks(32);
      reset = 1'b1;
      wait_clks(2);
      checks++;
      if (rx_valid !== 1'b0 || frame_err !== 1'b0 ||
          overrun !== 1'b0 || rx_data !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_outs got %b%b%b/%h want 000/00",
                  rx_valid, frame_err, overrun, rx_data);
      end
      wait_clks(30);
      for (int i = 5; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_hold got %b/%h want 0/00",
                  rx_valid, rx_data);
      end
      reset = 1'b0;
      wait_clks(BITCLK);
      send_frame(8'h81, 1'b1);
      wait_clks(40);
      checks++;
      if (acc_q.size() !== 1) begin
         errors++;
         $display("FAIL rstmid_nacc got %0d want 1", acc_q.size());
      end else if (acc_q[0] !== 8'h81) begin
         errors++;
         $display("FAIL rstmid_byte got %h want 81", acc_q[0]);
      end
      checks++;
      if (fe_cyc !== 0 || ov_cyc !== 0) begin
         errors++;
         $display("FAIL rstmid_flags got %0d/%0d want 0/0",
                  fe_cyc, ov_cyc);
      end
      rx_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
